// File: rtl/bp_gshare_btb.sv
// Fetch-stage branch predictor: tagged direct-mapped BTB plus a PHT of saturating
// counters, optionally gshare-indexed through a global history register.
module bp_gshare_btb #(
   parameter int INDEX_BITS = 10,
   parameter int ALIGN_BITS = 2,
   parameter int CTR_BITS   = 2,
   parameter int HIST_BITS  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [63:0]           in_pc,
   input  logic                  in_stall_from_icache,
   input  logic                  in_stall_from_dcache,
   input  logic                  in_stall_from_hazardunit,
   input  logic                  in_write_to_bp,
   input  logic [63:0]           in_branch_source,
   input  logic [63:0]           in_branch_target,
   input  logic                  in_is_update_state,
   input  logic                  in_is_actual_branch_taken,
   input  logic [INDEX_BITS-1:0] in_pred_idx,
   output logic [63:0]           out_pc,
   output logic                  out_miss,
   output logic                  is_branch_taken,
   output logic [INDEX_BITS-1:0] out_pred_idx
);

   localparam int ENTRIES  = 1 << INDEX_BITS;
   localparam int TAG_LSB  = ALIGN_BITS + INDEX_BITS;
   localparam int TAG_BITS = 64 - TAG_LSB;
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

   logic                  btb_valid  [ENTRIES];
   logic [TAG_BITS-1:0]   btb_tag    [ENTRIES];
   logic [63:0]           btb_target [ENTRIES];
   logic [CTR_BITS-1:0]   pht        [ENTRIES];

   logic                  write_en;
   logic [INDEX_BITS-1:0] lookup_idx;
   logic [TAG_BITS-1:0]   lookup_tag;
   logic [INDEX_BITS-1:0] alloc_idx;
   logic [TAG_BITS-1:0]   alloc_tag;
   logic [INDEX_BITS-1:0] pht_idx;
   logic                  hit;
   logic [CTR_BITS-1:0]   cur_ctr;
   logic [CTR_BITS-1:0]   next_ctr;

   assign write_en   = !(in_stall_from_icache || in_stall_from_dcache || in_stall_from_hazardunit);
   assign lookup_idx = in_pc[TAG_LSB-1:ALIGN_BITS];
   assign lookup_tag = in_pc[63:TAG_LSB];
   assign alloc_idx  = in_branch_source[TAG_LSB-1:ALIGN_BITS];
   assign alloc_tag  = in_branch_source[63:TAG_LSB];

   // The GHR only exists in gshare mode; bimodal indexes the PHT with the PC bits alone.
   generate
      if (HIST_BITS > 0) begin : g_gshare
         logic [HIST_BITS-1:0] ghr;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               ghr <= '0;
            end else if (write_en && in_is_update_state) begin
               ghr <= (ghr << 1) | HIST_BITS'(in_is_actual_branch_taken);
            end
         end

         assign pht_idx = lookup_idx ^ INDEX_BITS'(ghr);
      end else begin : g_bimodal
         assign pht_idx = lookup_idx;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_valid[i] <= 1'b0;
         end
      end else if (write_en && in_write_to_bp) begin
         btb_valid[alloc_idx] <= 1'b1;
      end
   end

   // Tag and target are meaningless while the valid bit is clear, so they carry no reset.
   always_ff @(posedge clk) begin
      if (write_en && in_write_to_bp) begin
         btb_tag[alloc_idx]    <= alloc_tag;
         btb_target[alloc_idx] <= in_branch_target;
      end
   end

   always_comb begin
      cur_ctr  = pht[in_pred_idx];
      next_ctr = cur_ctr;
      if (in_is_actual_branch_taken) begin
         if (cur_ctr != CTR_MAX) next_ctr = cur_ctr + 1'b1;
      end else begin
         if (cur_ctr != '0) next_ctr = cur_ctr - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            pht[i] <= CTR_INIT;
         end
      end else if (write_en && in_is_update_state) begin
         pht[in_pred_idx] <= next_ctr;
      end
   end

   assign hit             = btb_valid[lookup_idx] && (btb_tag[lookup_idx] == lookup_tag);
   assign out_miss        = !hit;
   assign is_branch_taken = hit && pht[pht_idx][CTR_BITS-1];
   assign out_pc          = is_branch_taken ? btb_target[lookup_idx] : in_pc + 64'd4;
   assign out_pred_idx    = pht_idx;

endmodule
